// File: rtl/apb_master_bridge_pkg.sv
// Shared APB bridge definitions: FSM state encoding, address-map constants, slave limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Peripheral window is addr[31:28] == APB_REGION; the slave index sits at addr[15:12].
  localparam logic [3:0] APB_REGION     = 4'h1;
  localparam int         SLV_IDX_LSB    = 12;
  localparam int         NUM_SLAVES_MAX = 16;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of core-side request/response and APB bus signals for the bridge.
// Latency: n/a (wires only).
// Backpressure: none; the core waits for the ready strobe.
// Ports (master = bridge): req/addr/we/wdata in, rdata/ready/err out,
//   PADDR/PWRITE/PWDATA/PENABLE/PSEL out, PRDATA/PREADY in.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);

  logic                     req;
  logic [31:0]              addr;
  logic                     we;
  logic [31:0]              wdata;
  logic [31:0]              rdata;
  logic                     ready;
  logic                     err;

  logic [31:0]              PADDR;
  logic                     PWRITE;
  logic [31:0]              PWDATA;
  logic                     PENABLE;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic [NUM_SLAVES*32-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;

  // The bridge side.
  modport master (
    input  req, addr, we, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

  // The environment side: core plus APB slaves.
  modport slave (
    output req, addr, we, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational address decode into {mapped, slave index}.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: addr in (32); mapped out (1); idx out (4).
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic [31:0] addr,
  output logic        mapped,
  output logic [3:0]  idx
);

  logic in_region;
  logic unused_addr_bits;

  always_comb begin
    idx       = addr[SLV_IDX_LSB +: 4];
    in_region = (addr[31:28] == APB_REGION);
    // Index values at or above NUM_SLAVES fall in the window but have no slave behind them.
    mapped    = in_region && ({28'd0, idx} < 32'(NUM_SLAVES));
  end

  // Offset bits are the slave's business, not the decoder's.
  assign unused_addr_bits = ^{addr[27:16], addr[11:0]};

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: single-cycle core request -> SETUP/ACCESS transfer -> one-cycle ready/err strobe.
// Latency: 3 cycles req->ready with zero-wait slave, +1 per wait cycle; 1 cycle if unmapped; TIMEOUT+2 on abort.
// Backpressure: one transfer at a time; req outside IDLE is dropped, not queued.
// Ports: PCLK, PRESET (async, active-low); bus (master modport): core req/addr/we/wdata -> rdata/ready/err,
//   APB PADDR/PWRITE/PWDATA/PENABLE/PSEL out, PRDATA/PREADY in.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,   // 1..NUM_SLAVES_MAX
  parameter int TIMEOUT    = 255  // >= 2
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Abort decision is taken on the edge where the counter would step onto TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state_q,   state_d;
  logic [3:0]            idx_q,     idx_d;
  logic [31:0]           paddr_q,   paddr_d;
  logic                  pwrite_q,  pwrite_d;
  logic [31:0]           pwdata_q,  pwdata_d;
  logic [NUM_SLAVES-1:0] psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [31:0]           rdata_q,   rdata_d;
  logic                  ready_q,   ready_d;
  logic                  err_q,     err_d;

  logic                  dec_mapped;
  logic [3:0]            dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;

  apb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_dec (
    .addr  (bus.addr),
    .mapped(dec_mapped),
    .idx   (dec_idx)
  );

  // One-hot select for the incoming request, and the return-path mux for the latched slave.
  // Only the latched slave's PREADY/PRDATA are ever looked at.
  always_comb begin
    dec_onehot = '0;
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (dec_idx == 4'(i));
      if (idx_q == 4'(i)) begin
        pready_sel = bus.PREADY[i];
        prdata_sel = bus.PRDATA[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (dec_mapped) begin
            state_d   = ST_SETUP;
            idx_d     = dec_idx;
            paddr_d   = bus.addr;
            pwrite_d  = bus.we;
            pwdata_d  = bus.wdata;
            psel_d    = dec_onehot;
            penable_d = 1'b0;
          end else begin
            // Unmapped: answer immediately with an error, bus untouched.
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        // PREADY is checked first so a response on the timeout edge still completes.
        if (pready_sel) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? 32'd0 : prdata_sel;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          cnt_d     = cnt_q + CNT_W'(1);
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int NS = 4;
  localparam int TO = 8;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.NUM_SLAVES(NS)) bus();

  apb_master_bridge #(
    .NUM_SLAVES(NS),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            cyc;
    logic [NS-1:0] psel;
    logic [31:0]   paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    int            acc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wait_cyc[NS];
  int          acc_cnt[NS];
  logic        toggle3;
  logic [31:0] last_rdata;
  logic        prev_sel;
  int          acc_seen;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Slave model: PREADY[i] rises on the (wait_cyc[i]+1)-th ACCESS cycle.
  // Slave 3 can be made to toggle PREADY while it is not selected.
  always @(negedge PCLK) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        bus.PREADY[i] = (acc_cnt[i] == wait_cyc[i]);
        acc_cnt[i]++;
      end else begin
        acc_cnt[i] = 0;
        if (i == 3 && toggle3) bus.PREADY[i] = ~bus.PREADY[i];
        else                   bus.PREADY[i] = 1'b0;
      end
    end
  end

  // Monitor: checks APB phase/hold behaviour every cycle and pops the scoreboard on ready.
  always @(negedge PCLK) begin
    exp_t x;
    if (!PRESET) begin
      chk("rst_ready", {31'd0, bus.ready}, 32'd0);
      chk("rst_psel", {28'd0, bus.PSEL}, 32'd0);
      prev_sel   = 1'b0;
      acc_seen   = 0;
      last_rdata = 32'd0;
    end else begin
      if (bus.PSEL != '0) begin
        if (sb.size() == 0) fail_now("spurious_psel");
        else begin
          chk("psel",   {28'd0, bus.PSEL},   {28'd0, sb[0].psel});
          chk("paddr",  bus.PADDR,           sb[0].paddr);
          chk("pwrite", {31'd0, bus.PWRITE}, {31'd0, sb[0].pwrite});
          chk("pwdata", bus.PWDATA,          sb[0].pwdata);
        end
        chk("penable_phase", {31'd0, bus.PENABLE}, {31'd0, prev_sel});
        if (bus.PENABLE) acc_seen++;
      end else begin
        chk("penable_idle", {31'd0, bus.PENABLE}, 32'd0);
      end
      if (bus.ready) begin
        if (sb.size() == 0) fail_now("spurious_ready");
        else begin
          x = sb.pop_front();
          chk("rdata",       bus.rdata,         x.rdata);
          chk("err",         {31'd0, bus.err},  {31'd0, x.err});
          chk("ready_cycle", cyc,               x.cyc);
          chk("access_cnt",  acc_seen,          x.acc);
          last_rdata = x.rdata;
        end
        acc_seen = 0;
      end else begin
        chk("rdata_hold", bus.rdata,        last_rdata);
        chk("err_idle",   {31'd0, bus.err}, 32'd0);
      end
      prev_sel = (bus.PSEL != '0);
    end
  end

  // Called #1 after a rising edge; req is sampled on the next edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [NS-1:0] psel, input logic [31:0] rd, input logic e,
                       input int lat, input int acc);
    exp_t x;
    x.rdata = rd; x.err = e; x.cyc = cyc + lat; x.psel = psel;
    x.paddr = a;  x.pwrite = w; x.pwdata = d;  x.acc = acc;
    sb.push_back(x);
    bus.req = 1'b1; bus.addr = a; bus.we = w; bus.wdata = d;
    @(posedge PCLK); #1;
    bus.req = 1'b0; bus.addr = 32'hDEAD_BEEF; bus.we = ~w; bus.wdata = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  initial begin
    int n;
    PRESET = 1'b1;
    bus.req = 1'b0; bus.addr = '0; bus.we = 1'b0; bus.wdata = '0; bus.PRDATA = '0;
    toggle3 = 1'b0;
    for (int i = 0; i < NS; i++) wait_cyc[i] = 0;
    #2 PRESET = 1'b0;
    #1;
    chk("reset_psel",    {28'd0, bus.PSEL},    32'd0);
    chk("reset_penable", {31'd0, bus.PENABLE}, 32'd0);
    chk("reset_ready",   {31'd0, bus.ready},   32'd0);
    chk("reset_err",     {31'd0, bus.err},     32'd0);
    chk("reset_rdata",   bus.rdata,            32'd0);
    chk("reset_paddr",   bus.PADDR,            32'd0);
    chk("reset_pwdata",  bus.PWDATA,           32'd0);
    chk("reset_pwrite",  {31'd0, bus.PWRITE},  32'd0);
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(posedge PCLK); #1;

    bus.PRDATA[0*32 +: 32] = 32'h0000_00A5;
    bus.PRDATA[1*32 +: 32] = 32'h1111_1111;
    bus.PRDATA[2*32 +: 32] = 32'h2222_2222;
    bus.PRDATA[3*32 +: 32] = 32'h3333_3333;

    // Read slave 0, PREADY on second ACCESS cycle: ready at req+4.
    wait_cyc[0] = 1;
    issue(32'h1000_0004, 1'b0, 32'h0, 4'b0001, 32'h0000_00A5, 1'b0, 4, 2);
    wait_done();

    // Unmapped: other region, index 15, index 4 (first past NUM_SLAVES). ready at req+1.
    issue(32'h2000_0000, 1'b0, 32'h0,         4'b0000, 32'h0, 1'b1, 1, 0);
    issue(32'h1000_F000, 1'b0, 32'h0,         4'b0000, 32'h0, 1'b1, 1, 0);
    issue(32'h1000_4000, 1'b1, 32'h1234_5678, 4'b0000, 32'h0, 1'b1, 1, 0);
    wait_done();

    // Highest mapped slave, zero-wait read.
    wait_cyc[3] = 0;
    issue(32'h1000_300C, 1'b0, 32'h0, 4'b1000, 32'h3333_3333, 1'b0, 3, 1);
    wait_done();

    // Timeout on slave 2 (never ready); a stray req mid-ACCESS must be ignored.
    wait_cyc[2] = 255;
    issue(32'h1000_2010, 1'b0, 32'h0, 4'b0100, 32'h0, 1'b1, TO + 2, TO);
    repeat (3) @(posedge PCLK);
    #1;
    bus.req = 1'b1; bus.addr = 32'h1000_3000; bus.we = 1'b1; bus.wdata = 32'h5555_5555;
    @(posedge PCLK); #1;
    bus.req = 1'b0; bus.addr = 32'hDEAD_BEEF;
    wait_done();

    // Good transfer after timeout.
    wait_cyc[0] = 0;
    issue(32'h1000_0000, 1'b0, 32'h0, 4'b0001, 32'h0000_00A5, 1'b0, 3, 1);
    wait_done();

    // Reset in the middle of ACCESS: no ready, everything cleared at once.
    wait_cyc[1] = 255;
    issue(32'h1000_1004, 1'b0, 32'h0, 4'b0010, 32'h0, 1'b0, 3, 1);
    repeat (3) @(posedge PCLK);
    #1;
    chk("pre_rst_penable", {31'd0, bus.PENABLE}, 32'd1);
    #2 PRESET = 1'b0;
    sb.delete();
    #1;
    chk("midrst_psel",    {28'd0, bus.PSEL},    32'd0);
    chk("midrst_penable", {31'd0, bus.PENABLE}, 32'd0);
    chk("midrst_ready",   {31'd0, bus.ready},   32'd0);
    chk("midrst_rdata",   bus.rdata,            32'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b1;
    wait_cyc[1] = 0;
    @(posedge PCLK); #1;
    issue(32'h1000_1004, 1'b0, 32'h0, 4'b0010, 32'h1111_1111, 1'b0, 3, 1);
    wait_done();

    // Zero-wait write to slave 1: rdata returns 0 on writes.
    issue(32'h1000_1000, 1'b1, 32'h0000_00FF, 4'b0010, 32'h0, 1'b0, 3, 1);
    wait_done();

    // Back-to-back: slave 2 (two waits) while PREADY[3] toggles, then slave 3 on the ready cycle.
    wait_cyc[2] = 2;
    wait_cyc[3] = 0;
    toggle3 = 1'b1;
    issue(32'h1000_2008, 1'b0, 32'h0, 4'b0100, 32'h2222_2222, 1'b0, 5, 3);
    n = 0;
    while (!bus.ready && n < 50) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (!bus.ready) fail_now("b2b_first_ready_missing");
    toggle3 = 1'b0;
    issue(32'h1000_300C, 1'b0, 32'h0, 4'b1000, 32'h3333_3333, 1'b0, 3, 1);
    wait_done();

    repeat (3) @(posedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
